// File: rtl/simon_keypad.sv
// simon_keypad: debounced four-button keypad for the Simon game.
// Raw buttons pass through a 2-flop synchronizer and a stability filter. A
// small FSM then turns each clean single-button press into one playerPressed
// strobe. There is no auto-repeat, and chords lock the keypad until every
// button is released.
// Optional feature: define SIMON_KEYPAD_LED_ECHO_EN to light the echo lamp of
// the accepted button while it is held; otherwise led is tied to 0.
module simon_keypad #(
  parameter int DEBOUNCE = 3  // stable edges needed to accept a change (1..15)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       enable,
  output logic [1:0] playerNum,
  output logic       playerPressed,
  output logic       multi,
  output logic [3:0] led
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    LOCKED = 2'd2
  } keyState_t;

  keyState_t  state, stateNext;
  logic [3:0] s1, s2;
  logic [3:0] db;
  logic [3:0] stableCnt;
  logic       pressNext;
  logic       dbMany, dbOneHot;
  logic [1:0] dbIndex;

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      // NOTE: non-blocking, so s2 takes the old s1 and the chain stays two flops deep.
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Stability filter. When s1 differs from s2, s2 changes at this edge, so
  // the count restarts. db takes s2 only after DEBOUNCE quiet edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db        <= '0;
      stableCnt <= '0;
    end else if (s1 != s2) begin
      stableCnt <= '0;
    end else if (s2 == db) begin
      stableCnt <= '0;
    end else if (stableCnt == 4'(DEBOUNCE - 1)) begin
      db        <= s2;
      stableCnt <= '0;
    end else begin
      stableCnt <= stableCnt + 4'd1;
    end
  end

  // Decode the debounced vector: a chord, a single button, and the index of
  // that single button.
  assign dbMany   = (db & (db - 4'd1)) != 4'd0;
  assign dbOneHot = (db != 4'd0) && !dbMany;
  assign dbIndex  = {db[3] | db[2], db[3] | db[1]};

  // Press FSM: next state and the press strobe.
  always_comb begin
    // NOTE: defaults come first so no path leaves a signal unassigned (no latches).
    stateNext = state;
    pressNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (dbMany) begin
          stateNext = LOCKED;
        end else if (dbOneHot) begin
          if (enable) begin
            stateNext = HELD;
            pressNext = 1'b1;
          end else begin
            stateNext = LOCKED;
          end
        end
      end
      HELD: begin
        if (db == 4'd0)  stateNext = IDLE;
        else if (dbMany) stateNext = LOCKED;
      end
      LOCKED: begin
        if (db == 4'd0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Register the state and the outputs, so the outputs are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      playerPressed <= 1'b0;
      playerNum     <= '0;
      multi         <= 1'b0;
    end else begin
      state         <= stateNext;
      playerPressed <= pressNext;
      multi         <= dbMany;
      if (pressNext) playerNum <= dbIndex;
    end
  end

`ifdef SIMON_KEYPAD_LED_ECHO_EN
  // Echo only the accepted button, and only while it is still held.
  assign led = (state == HELD) ? (db & (4'b0001 << playerNum)) : 4'b0000;
`else
  assign led = 4'b0000;
`endif

endmodule

// File: tb/tb_simon_keypad.sv
// Testbench for simon_keypad. It runs directed scenarios and then randomized
// button traffic. A behavioural keypad model, stepped once per clock edge,
// predicts every output.
module tb_simon_keypad;

  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       enable;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic       multi;
  logic [3:0] led;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  int pressCyc = 0;

  // Model state: raw samples, the debounced value, and the press bookkeeping.
  logic [3:0] hist[$];
  logic [3:0] mDb;
  logic [1:0] mNum;
  logic       mPressed, mMulti, mPrevZero, mAccepted;

  simon_keypad #(.DEBOUNCE(DB)) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .enable(enable),
    .playerNum(playerNum),
    .playerPressed(playerPressed),
    .multi(multi),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    mDb       = '0;
    mNum      = '0;
    mPressed  = 1'b0;
    mMulti    = 1'b0;
    mPrevZero = 1'b1;
    mAccepted = 1'b0;
  endtask

  // A press is accepted at the first edge after the debounced value leaves 0,
  // if it left 0 to exactly one button and the player is enabled. The
  // debounced value is the raw input once D+1 successive samples agree.
  task automatic modelStep(input logic [3:0] b, input logic en);
    logic [3:0] dbPre;
    bit         same;
    dbPre    = mDb;
    mPressed = mPrevZero && ($countones(dbPre) == 1) && en;
    if (mPressed) begin
      for (int i = 0; i < 4; i++) if (dbPre[i]) mNum = 2'(i);
      mAccepted = 1'b1;
    end else if (dbPre == 4'd0 || $countones(dbPre) >= 2) begin
      mAccepted = 1'b0;
    end
    mMulti    = $countones(dbPre) >= 2;
    mPrevZero = (dbPre == 4'd0);
    if (hist.size() == DB + 1) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
      if (same) mDb = hist[0];
    end
    hist.push_back(b);
    if (hist.size() > DB + 1) void'(hist.pop_front());
  endtask

  function automatic logic [3:0] modelLed();
`ifdef SIMON_KEYPAD_LED_ECHO_EN
    return mAccepted ? (mDb & (4'b0001 << mNum)) : 4'b0000;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic checkOutputs();
    check("pressed", playerPressed, mPressed);
    check("num", playerNum, mNum);
    check("multi", multi, mMulti);
    check("led", led, modelLed());
  endtask

  // One clock: step the model at the rising edge, then check on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) modelStep(btn, enable);
    cyc++;
    @(negedge clk);
    checkOutputs();
    if (playerPressed) begin
      pulses++;
      pressCyc = cyc;
    end
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    btn = b;
    repeat (n) cycle();
  endtask

  // Reset is asserted between edges, and the outputs must clear at once.
  task automatic applyReset(input int n);
    reset = 1'b1;
    #1;
    modelReset();
    check("rst_pressed", playerPressed, 1'b0);
    check("rst_num", playerNum, 2'd0);
    check("rst_multi", multi, 1'b0);
    check("rst_led", led, 4'd0);
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  initial begin
    int startCyc;
    int budget;
    reset  = 1'b1;
    btn    = '0;
    enable = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutputs();

    // Single press of button 2: one strobe, DB+2 edges after the first sampling edge.
    enable   = 1'b1;
    pulses   = 0;
    startCyc = cyc;
    hold(4'b0100, 10);
    check("p2_latency", pressCyc - (startCyc + 1), DB + 2);
    hold(4'b0000, 8);
    check("p2_pulses", pulses, 1);
    check("p2_num", playerNum, 2'd2);

    // A bouncing button never settles, so there is no press.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      cycle();
    end
    hold(4'b0000, 6);
    check("bounce_pulses", pulses, 0);
    check("bounce_num", playerNum, 2'd2);

    // Button 0, then a chord: one strobe, then multi and a lockout.
    pulses = 0;
    hold(4'b0001, 10);
    hold(4'b0011, 10);
    check("chord_multi", multi, 1'b1);
    check("chord_pulses", pulses, 1);
    check("chord_num", playerNum, 2'd0);
    hold(4'b0000, 8);
    check("chord_release", multi, 1'b0);

    // A press made while disabled stays locked until it is released.
    pulses = 0;
    enable = 1'b0;
    hold(4'b1000, 10);
    enable = 1'b1;
    hold(4'b1000, 10);
    check("lock_pulses", pulses, 0);
    hold(4'b0000, 8);
    hold(4'b1000, 10);
    check("relock_pulses", pulses, 1);
    check("relock_num", playerNum, 2'd3);
    hold(4'b0000, 8);

    // A long hold gives no auto-repeat. The echo lamp follows the held button.
    pulses = 0;
    hold(4'b0010, 40);
    check("long_pulses", pulses, 1);
`ifdef SIMON_KEYPAD_LED_ECHO_EN
    check("long_led", led, 4'b0010);
`else
    check("long_led", led, 4'b0000);
`endif
    hold(4'b0000, 6);
    check("long_led_off", led, 4'b0000);

    // Reset mid-debounce; the button is held across release and counts as a new press.
    btn = 4'b0001;
    cycle();
    cycle();
    pulses = 0;
    applyReset(2);
    startCyc = cyc;
    hold(4'b0001, 10);
    check("rst_press_latency", pressCyc - (startCyc + 1), DB + 2);
    check("rst_press_pulses", pulses, 1);
    check("rst_press_num", playerNum, 2'd0);
    hold(4'b0000, 8);

    // Reset in the strobe cycle aborts the strobe. A fresh debounce then yields a new strobe.
    btn    = 4'b0100;
    budget = 20;
    pulses = 0;
    while (pulses == 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check("abort_wait", pulses, 1);
    applyReset(1);
    pulses = 0;
    hold(4'b0100, 10);
    check("abort_repress", pulses, 1);
    check("abort_num", playerNum, 2'd2);
    hold(4'b0000, 8);

    // Random traffic: short and long holds, chords, enable flips, rare resets.
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) applyReset($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       hold(4'b0000, $urandom_range(1, 8));
        1:       hold(4'(1 << $urandom_range(0, 3)), $urandom_range(1, 12));
        default: hold(4'($urandom_range(0, 15)), $urandom_range(1, 8));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_keypad.md
SIMON_KEYPAD -- requirements
Module: simon_keypad

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 3, meaning consecutive stable clock cycles needed to accept a button change (legal range 1..15).
REQ-002 SHALL have port clk  input  1  system clock (60 Hz game tick); all state is updated on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port btn  input  4  raw, asynchronous, active-high push buttons; btn[i] selects colour code i.
REQ-005 SHALL have port enable  input  1  high when the player may press (driven from the inverse of the game's turn flag, gated by not-game-over).
REQ-006 SHALL have port playerNum  output  2  code of the last accepted press; held stable between presses.
REQ-007 SHALL have port playerPressed  output  1  single-cycle strobe marking one accepted press.
REQ-008 SHALL have port multi  output  1  high while more than one debounced button is down.
REQ-009 SHALL have port led  output  4  echo lamps (see Configuration).

Function
REQ-010 SHALL pass btn through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 SHALL keep a debounced vector db[3:0] that takes the value of s2 only after s2 has held that value for DEBOUNCE consecutive edges; any change in s2 restarts the count.
REQ-012 SHALL give, for DEBOUNCE=3, a rising playerPressed in the cycle after edge E0+5, where E0 is the first edge sampling the new btn value (latency = DEBOUNCE+2 edges).
REQ-013 SHALL implement FSM states IDLE, HELD, LOCKED; reset state IDLE.
REQ-014 IDLE: db=0 -> stay; db one-hot and enable=1 -> HELD, assert playerPressed for exactly one cycle, load playerNum with the index of the set bit; db one-hot and enable=0 -> LOCKED; db with >=2 bits set -> LOCKED.
REQ-015 HELD: db=0 -> IDLE; db gains a second bit -> LOCKED; otherwise stay; no further strobes.
REQ-016 LOCKED: db=0 -> IDLE; otherwise stay; no strobes.
REQ-017 SHALL not auto-repeat: a held button yields exactly one strobe until db returns to 0.
REQ-018 SHALL ignore a deassertion of enable while in HELD (strobe already issued, no retraction).
REQ-019 SHALL drive multi combinationally-free (registered) as 1 when popcount(db)>=2, one cycle after db changes.
REQ-020 SHALL ignore bounces shorter than DEBOUNCE cycles entirely (no db change, no strobe).

Reset
REQ-021 SHALL on reset clear s1, s2, db, stability counter, playerNum=0, playerPressed=0, multi=0, led=0, FSM=IDLE, immediately and asynchronously.
REQ-022 SHALL treat a button held across reset release as a new press once debounced (strobe issued if enable=1).
REQ-023 SHALL abort an in-flight strobe if reset asserts in the same cycle; no strobe follows until a fresh debounce completes.

Configuration
REQ-024 SHALL use macro SIMON_KEYPAD_LED_ECHO_EN: defined -> led equals db masked to the accepted button while FSM=HELD (one-hot on bit playerNum), else 0; undefined -> led constant 0 and no echo logic synthesized.

Verification
REQ-025 btn=4'b0100 held 10 cycles, enable=1, DEBOUNCE=3 -> one playerPressed pulse after edge E0+5, playerNum=2, multi=0.
REQ-026 btn[1] toggling every cycle for 8 cycles then low -> no playerPressed, db stays 0, playerNum unchanged.
REQ-027 btn=4'b0001 then btn=4'b0011 (both held 10 cycles) -> one pulse playerNum=0, then multi=1, FSM=LOCKED, no second pulse; release -> multi=0, IDLE.
REQ-028 enable=0, btn=4'b1000 held 10 cycles, then enable=1 while still held -> no pulse; release, press again -> one pulse, playerNum=3.
REQ-029 btn=4'b0010 held 40 cycles -> exactly one pulse; with SIMON_KEYPAD_LED_ECHO_EN defined led=4'b0010 while held, 0 after release; undefined led=0 throughout.
REQ-030 reset pulsed mid-debounce of btn=4'b0001 -> all outputs 0 immediately; after release of reset with button held -> pulse DEBOUNCE+2 edges later, playerNum=0.
